// File: rtl/up_down_counter.sv
// Prescaled wrap-around up/down counter: the prescaler runs every clock and its
// terminal count gates a single step of the direction-controlled counter.
module up_down_counter #(
    parameter int DIV_WIDTH = 3,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    output logic [DIV_WIDTH-1:0] clk_d,
    output logic [CNT_WIDTH-1:0] counter
);

    logic                 tick;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    // Terminal count of the prescaler; this is an enable, never a derived clock.
    assign tick = &clk_d;

    always_comb begin
        cnt_nxt = counter;
        if (tick)
            cnt_nxt = mode ? counter + 1'b1 : counter - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_d   <= '0;
            counter <= '0;
        end else begin
            clk_d   <= clk_d + 1'b1;
            counter <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: each stimulus edge queues the expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_up_down_counter;

    localparam int DW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic [DW-1:0] clk_d;
    logic [CW-1:0] counter;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] e_d;
    logic [CW-1:0] e_c;
    int            nvec = 0;
    int            nerr = 0;

    up_down_counter #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .clk_d  (clk_d),
        .counter(counter)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable at the falling edge, half a cycle after the update.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("sb_clk_d", int'(clk_d), int'(e.d));
            cmp("sb_counter", int'(counter), int'(e.c));
        end
    end

    // One rising edge with the given mode; expected result pushed after the edge.
    task automatic step(input logic m);
        exp_t e;
        mode = m;
        @(posedge clk);
        #1;
        if (e_d == DW'(7))
            e_c = m ? e_c + 1'b1 : e_c - 1'b1;
        e_d = e_d + 1'b1;
        e.d = e_d;
        e.c = e_c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        cmp("rst_async_clk_d", int'(clk_d), 0);
        cmp("rst_async_counter", int'(counter), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        e_d = '0;
        e_c = '0;
    endtask

    initial begin
        e_d = '0;
        e_c = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_clk_d", int'(clk_d), 0);
        cmp("reset_counter", int'(counter), 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Up count: step at edge 8 and 16.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1);
            if (i == 7)  cmp("up_e7_counter", int'(counter), 0);
            if (i == 8)  cmp("up_e8_counter", int'(counter), 1);
            if (i == 16) cmp("up_e16_counter", int'(counter), 2);
        end
        // Run on to edge 29 (clk_d=5, counter=3), then reset mid-period.
        for (int i = 17; i <= 29; i++) step(1'b1);
        cmp("pre_rst_clk_d", int'(clk_d), 5);
        cmp("pre_rst_counter", int'(counter), 3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        cmp("mid_rst_clk_d", int'(clk_d), 0);
        cmp("mid_rst_counter", int'(counter), 0);
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_hold_clk_d", int'(clk_d), 0);
        cmp("rst_hold_counter", int'(counter), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        e_d = '0;
        e_c = '0;

        // Up wrap over 64 edges.
        for (int i = 1; i <= 64; i++) begin
            step(1'b1);
            if (i == 56) cmp("wrap_e56_counter", int'(counter), 7);
            if (i == 64) cmp("wrap_e64_counter", int'(counter), 0);
        end

        // Down count with underflow.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b0);
            if (i == 8)  cmp("down_e8_counter", int'(counter), 7);
            if (i == 16) cmp("down_e16_counter", int'(counter), 6);
        end

        // Direction change mid-period.
        do_reset();
        for (int i = 1; i <= 19; i++) step(1'b1);
        cmp("dir_e19_counter", int'(counter), 2);
        cmp("dir_e19_clk_d", int'(clk_d), 3);
        for (int i = 20; i <= 32; i++) begin
            step(1'b0);
            if (i == 23) cmp("dir_e23_counter", int'(counter), 2);
            if (i == 24) cmp("dir_e24_counter", int'(counter), 1);
            if (i == 24) cmp("dir_e24_clk_d", int'(clk_d), 0);
        end

        // Mode glitches between ticks; only the tick-edge value matters.
        do_reset();
        begin
            logic [7:0] pat;
            pat = 8'b1010_0100; // bit k-1 = mode for edge k; edge 8 has mode=1
            for (int i = 1; i <= 8; i++) begin
                step(pat[i-1]);
                if (i == 7) cmp("glitch_e7_counter", int'(counter), 0);
            end
            cmp("glitch_e8_counter", int'(counter), 1);
        end

        repeat (2) @(negedge clk);
        #1;
        cmp("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
